// File: rtl/fifo_loc_tracker.sv
// Single-clock FIFO controller with integrated storage: tracks free locations,
// registered FULL/EMPTY flags and sticky overflow/underflow error flags.
module fifo_loc_tracker #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC,
    input  logic                  CLR_ERR,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    output logic [ADDR_WIDTH:0]   empty_loc,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int                  DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] SIZE    = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LOC_ONE = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [ADDR_WIDTH:0]   loc_next;

    // Acceptance is judged on the pre-edge count, so a full FIFO never writes
    // and an empty one never reads, even when both requests arrive together.
    assign wr_acc = W_INC && (empty_loc != '0);
    assign rd_acc = R_INC && (empty_loc != SIZE);

    always_comb begin
        // NOTE: assign a default first so every path drives loc_next; a missing
        // branch assignment in always_comb would infer a latch.
        loc_next = empty_loc;
        if (wr_acc && !rd_acc) begin
            loc_next = empty_loc - LOC_ONE;
        end else if (rd_acc && !wr_acc) begin
            loc_next = empty_loc + LOC_ONE;
        end
    end

    // NOTE: storage has no reset; only pointers define which words are valid,
    // and leaving the array unreset lets it map onto plain RAM.
    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wr_ptr] <= WR_DATA;
        end
    end

    // NOTE: non-blocking assignments throughout sequential logic so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            empty_loc <= SIZE;
            FULL      <= 1'b0;
            EMPTY     <= 1'b1;
            RD_DATA   <= '0;
            RD_VALID  <= 1'b0;
            OVERFLOW  <= 1'b0;
            UNDERFLOW <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            RD_VALID <= rd_acc;
            if (rd_acc) begin
                RD_DATA <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + PTR_ONE;
            end

            // Flags follow the next-state count so they move with empty_loc.
            empty_loc <= loc_next;
            FULL      <= (loc_next == '0);
            EMPTY     <= (loc_next == SIZE);

            // Set has priority over clear on the same edge.
            if (W_INC && FULL) begin
                OVERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                OVERFLOW <= 1'b0;
            end

            if (R_INC && EMPTY) begin
                UNDERFLOW <= 1'b1;
            end else if (CLR_ERR) begin
                UNDERFLOW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_loc_tracker.sv
// Directed self-checking bench for fifo_loc_tracker (DATA_WIDTH=8, ADDR_WIDTH=4).
module tb_fifo_loc_tracker;

    logic       clk;
    logic       rst;
    logic       w_inc;
    logic [7:0] wr_data;
    logic       r_inc;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [4:0] empty_loc;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;

    int checks;
    int failures;

    fifo_loc_tracker #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .CLK       (clk),
        .RST       (rst),
        .W_INC     (w_inc),
        .WR_DATA   (wr_data),
        .R_INC     (r_inc),
        .CLR_ERR   (clr_err),
        .RD_DATA   (rd_data),
        .RD_VALID  (rd_valid),
        .empty_loc (empty_loc),
        .FULL      (full),
        .EMPTY     (empty),
        .OVERFLOW  (overflow),
        .UNDERFLOW (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        w_inc   = 1'b0;
        r_inc   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        w_inc   = 1'b1;
        wr_data = d;
        step();
        w_inc   = 1'b0;
    endtask

    task automatic clear_errors();
        idle();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle();
        wr_data = 8'h00;
        step();
        step();
        rst = 1'b1;
        step();
        checks++; if (empty_loc !== 5'd16) begin failures++; $display("FAIL reset_empty_loc got=%0d exp=16", empty_loc); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data got=%h exp=00", rd_data); end
        checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL reset_err_flags got=%b exp=00", {overflow, underflow}); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            w_inc   = 1'b1;
            wr_data = 8'(i);
            step();
            checks++; if (empty_loc !== 5'(15 - i)) begin failures++; $display("FAIL fill_empty_loc[%0d] got=%0d exp=%0d", i, empty_loc, 15 - i); end
            checks++; if (full !== (i == 15)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 15)); end
            checks++; if (empty !== 1'b0) begin failures++; $display("FAIL fill_empty[%0d] got=%b exp=0", i, empty); end
        end
        wr_data = 8'hAA;
        step();
        w_inc = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
        checks++; if (empty_loc !== 5'd0) begin failures++; $display("FAIL fill_reject_loc got=%0d exp=0", empty_loc); end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL fill_reject_full got=%b exp=1", full); end
        clear_errors();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fill_clr_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 16; i++) begin
            r_inc = 1'b1;
            step();
            checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL drain_valid[%0d] got=%b exp=1", i, rd_valid); end
            checks++; if (rd_data !== 8'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, rd_data, 8'(i)); end
            checks++; if (empty_loc !== 5'(i + 1)) begin failures++; $display("FAIL drain_empty_loc[%0d] got=%0d exp=%0d", i, empty_loc, i + 1); end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty); end
        step();
        r_inc = 1'b0;
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL drain_underflow got=%b exp=1", underflow); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL drain_reject_valid got=%b exp=0", rd_valid); end
        checks++; if (rd_data !== 8'h0F) begin failures++; $display("FAIL drain_hold_data got=%h exp=0f", rd_data); end
        checks++; if (empty_loc !== 5'd16) begin failures++; $display("FAIL drain_reject_loc got=%0d exp=16", empty_loc); end
        clear_errors();
        checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL drain_clr_underflow got=%b exp=0", underflow); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] model_q[$];
        logic [7:0] exp_d;
        for (int i = 0; i < 5; i++) begin
            push(8'h50 + 8'(i));
            model_q.push_back(8'h50 + 8'(i));
        end
        checks++; if (empty_loc !== 5'd11) begin failures++; $display("FAIL b2b_preload_loc got=%0d exp=11", empty_loc); end
        for (int i = 0; i < 20; i++) begin
            w_inc   = 1'b1;
            r_inc   = 1'b1;
            wr_data = 8'h60 + 8'(i);
            step();
            exp_d = model_q.pop_front();
            model_q.push_back(8'h60 + 8'(i));
            checks++; if (empty_loc !== 5'd11) begin failures++; $display("FAIL b2b_loc[%0d] got=%0d exp=11", i, empty_loc); end
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin failures++; $display("FAIL b2b_data[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp_d); end
        end
        w_inc = 1'b0;
        for (int i = 0; i < 5; i++) begin
            r_inc = 1'b1;
            step();
            exp_d = model_q.pop_front();
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp_d) begin failures++; $display("FAIL b2b_tail[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, exp_d); end
        end
        r_inc = 1'b0;
        checks++; if (empty !== 1'b1 || empty_loc !== 5'd16) begin failures++; $display("FAIL b2b_end got=%b/%0d exp=1/16", empty, empty_loc); end
        step();
    endtask

    task automatic test_simul_empty();
        w_inc   = 1'b1;
        r_inc   = 1'b1;
        wr_data = 8'h77;
        step();
        idle();
        checks++; if (empty_loc !== 5'd15) begin failures++; $display("FAIL sim_empty_loc got=%0d exp=15", empty_loc); end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL sim_empty_valid got=%b exp=0", rd_valid); end
        checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL sim_empty_underflow got=%b exp=1", underflow); end
        clear_errors();
        r_inc = 1'b1;
        step();
        r_inc = 1'b0;
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin failures++; $display("FAIL sim_empty_readback got=%b/%h exp=1/77", rd_valid, rd_data); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL sim_empty_after got=%b exp=1", empty); end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) begin
            push(8'h80 + 8'(i));
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL sim_full_filled got=%b exp=1", full); end
        // Clear and overflow on the same edge: set must win.
        clr_err = 1'b1;
        w_inc   = 1'b1;
        wr_data = 8'hCC;
        step();
        idle();
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL clr_vs_set_overflow got=%b exp=1", overflow); end
        checks++; if (empty_loc !== 5'd0) begin failures++; $display("FAIL clr_vs_set_loc got=%0d exp=0", empty_loc); end
        clear_errors();
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clr_overflow got=%b exp=0", overflow); end
        w_inc   = 1'b1;
        r_inc   = 1'b1;
        wr_data = 8'hEE;
        step();
        idle();
        checks++; if (empty_loc !== 5'd1) begin failures++; $display("FAIL sim_full_loc got=%0d exp=1", empty_loc); end
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h80) begin failures++; $display("FAIL sim_full_oldest got=%b/%h exp=1/80", rd_valid, rd_data); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL sim_full_flag got=%b exp=0", full); end
        for (int i = 1; i < 16; i++) begin
            r_inc = 1'b1;
            step();
            checks++; if (rd_data !== 8'h80 + 8'(i)) begin failures++; $display("FAIL sim_full_drain[%0d] got=%h exp=%h", i, rd_data, 8'h80 + 8'(i)); end
        end
        r_inc = 1'b0;
        checks++; if (empty !== 1'b1 || empty_loc !== 5'd16) begin failures++; $display("FAIL sim_full_dropped got=%b/%0d exp=1/16", empty, empty_loc); end
        clear_errors();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            push(8'h10 + 8'(i));
        end
        w_inc   = 1'b1;
        r_inc   = 1'b1;
        wr_data = 8'h17;
        step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h10 || empty_loc !== 5'd9) begin failures++; $display("FAIL arst_pre got=%b/%h/%0d exp=1/10/9", rd_valid, rd_data, empty_loc); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if (empty_loc !== 5'd16 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL arst_loc got=%0d/%b/%b exp=16/1/0", empty_loc, empty, full); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin failures++; $display("FAIL arst_read got=%b/%h exp=0/00", rd_valid, rd_data); end
        step();
        idle();
        rst = 1'b1;
        step();
        push(8'hA0);
        push(8'hA1);
        checks++; if (empty_loc !== 5'd14) begin failures++; $display("FAIL arst_after_loc got=%0d exp=14", empty_loc); end
        r_inc = 1'b1;
        step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA0) begin failures++; $display("FAIL arst_first got=%b/%h exp=1/a0", rd_valid, rd_data); end
        step();
        r_inc = 1'b0;
        checks++; if (rd_data !== 8'hA1 || empty !== 1'b1) begin failures++; $display("FAIL arst_second got=%h/%b exp=a1/1", rd_data, empty); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b0;
        w_inc    = 1'b0;
        r_inc    = 1'b0;
        clr_err  = 1'b0;
        wr_data  = 8'h00;
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_simul_empty();
        test_simul_full();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_loc_tracker.md
Name: fifo_loc_tracker

Overview:
Single-clock FIFO write/read controller with integrated storage. It maintains the free-location count `empty_loc`, which downstream flag logic decodes into full and empty. It also provides registered FULL and EMPTY flags of its own, plus sticky overflow and underflow error flags. It sits between a producer pushing with W_INC and a consumer popping with R_INC, and is the source of the `empty_loc` bus used by the team's FIFO flag comparators.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_WIDTH, 4, pointer width; depth SIZE = 2**ADDR_WIDTH

Ports:
CLK  input  1  sole clock; all state updates on rising edge
RST  input  1  asynchronous, active-low reset
W_INC  input  1  write request; data sampled on the same edge
WR_DATA  input  DATA_WIDTH  write data
R_INC  input  1  read request
RD_DATA  output  DATA_WIDTH  read data, registered
RD_VALID  output  1  one-cycle pulse: RD_DATA holds the word from the read accepted on the previous edge
empty_loc  output  ADDR_WIDTH+1  number of free locations, range 0..SIZE
FULL  output  1  registered; high iff empty_loc == 0
EMPTY  output  1  registered; high iff empty_loc == SIZE
OVERFLOW  output  1  sticky: write attempted while full
UNDERFLOW  output  1  sticky: read attempted while empty
CLR_ERR  input  1  synchronous clear of OVERFLOW and UNDERFLOW

Behaviour:
- Reset (RST low, asynchronous):
  - wr_ptr = 0, rd_ptr = 0
  - empty_loc = SIZE, EMPTY = 1, FULL = 0
  - RD_DATA = 0, RD_VALID = 0, OVERFLOW = 0, UNDERFLOW = 0
  - Memory contents are not reset.
- Acceptance, evaluated on the state before the edge:
  - wr_acc = W_INC && (empty_loc != 0)
  - rd_acc = R_INC && (empty_loc != SIZE)
  - No write-through when full; no read-through when empty.
- Write: on wr_acc, mem[wr_ptr] <= WR_DATA and wr_ptr <= wr_ptr + 1. The pointer wraps modulo SIZE (ADDR_WIDTH bits, natural rollover).
- Read: on rd_acc, RD_DATA <= mem[rd_ptr], rd_ptr <= rd_ptr + 1 (wraps modulo SIZE), and RD_VALID <= 1. When rd_acc is low, RD_VALID <= 0 and RD_DATA holds its value.
  - Read latency is one cycle: data appears the cycle after R_INC is accepted.
- empty_loc update:
  - wr_acc only: decrement by 1
  - rd_acc only: increment by 1
  - both, or neither: unchanged
  - Can never go below 0 or above SIZE.
- Simultaneous events:
  - Both requests while empty: only the write is accepted. empty_loc becomes SIZE-1 and RD_VALID stays 0.
  - Both requests while full: only the read is accepted. empty_loc becomes 1 and the write data is dropped.
  - Both requests at intermediate occupancy: both are accepted. The read returns the older word and never the word written on the same edge, unless occupancy was exactly 0, which is excluded by the rule above.
- FULL/EMPTY: registered from the next-state empty_loc, so they change on the same edge as empty_loc. There is no cycle of lag relative to empty_loc.
- OVERFLOW is set on the edge where W_INC && FULL. UNDERFLOW is set on the edge where R_INC && EMPTY.
  - CLR_ERR clears both on the next edge.
  - If a set condition and CLR_ERR occur on the same edge, set wins.
  - Rejected requests change no other state.
- Reset mid-operation: all state returns to the reset values immediately. Any data in flight is discarded. An RD_VALID pulse is cancelled if RST asserts.

Test Plan:
- Reset release, idle: empty_loc = 16, EMPTY = 1, FULL = 0, RD_VALID = 0, OVERFLOW = UNDERFLOW = 0.
- 16 consecutive writes of 0x00..0x0F: empty_loc counts down 16→0 and FULL rises on the 16th edge. A 17th W_INC is rejected, OVERFLOW = 1 and empty_loc stays 0.
- 16 reads from full: RD_DATA = 0x00..0x0F, each one cycle after its R_INC, with RD_VALID high each cycle. EMPTY = 1 after the 16th read. A further R_INC gives UNDERFLOW = 1 and RD_VALID = 0.
- Preload 5 words, then 20 cycles of simultaneous W_INC/R_INC: empty_loc holds at 11. Data emerges in order, and wr_ptr and rd_ptr wrap past 15→0 without loss.
- Simultaneous W_INC/R_INC when empty: empty_loc goes to 15 and RD_VALID stays 0. Simultaneous W_INC/R_INC when full: empty_loc goes to 1, the oldest word is returned, and the written word is absent on later reads.
- Assert RST asynchronously mid-burst with 7 words held: outputs return to reset values before the next edge, and subsequent writes start at address 0. CLR_ERR together with W_INC while FULL leaves OVERFLOW = 1.
